// File: rtl/mult_seq_if.sv
// Operand / result handshake bundle for the iterative multiplier.
// The master side issues operands and consumes results; the slave is mult_seq.
interface mult_seq_if #(
  parameter int W = 32
);
  logic         op_vld;
  logic         op_rdy;
  logic [1:0]   op;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         kill;
  logic         result_vld;
  logic         result_rdy;
  logic [W-1:0] result;

  modport master (
    output op_vld, op, op_a, op_b, kill, result_rdy,
    input  op_rdy, result_vld, result
  );

  modport slave (
    input  op_vld, op, op_a, op_b, kill, result_rdy,
    output op_rdy, result_vld, result
  );
endinterface

// File: rtl/mult_seq.sv
// Iterative shift-and-add multiplier, UNROLL multiplier bits per cycle.
// RISC-V MUL/MULH/MULHSU/MULHU: op_a is sign-extended into a 2W-bit
// multiplicand; for MULH the top multiplier bit carries negative weight.
// The interface instance must be built with the same W as this module.
module mult_seq #(
  parameter int W      = 32,
  parameter int UNROLL = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  mult_seq_if.slave bus
);
  localparam int N  = W / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                       state_q, state_d;
  logic [1:0]                   op_q, op_d;
  logic [2*W-1:0]               a_q, a_d;      // multiplicand, pre-shifted to current bit group
  logic [W-1:0]                 b_q, b_d;      // multiplier, next bit group in the LSBs
  logic [2*W-1:0]               acc_q, acc_d;
  logic [CW-1:0]                cnt_q, cnt_d;

  logic                         op_rdy, accept, last, sgn_a;
  logic [UNROLL-1:0][2*W-1:0]   pp;
  logic [2*W-1:0]               sum;

  assign last   = (cnt_q == CW'(N - 1));
  assign op_rdy = ((state_q == IDLE) || (state_q == DONE && bus.result_rdy)) && !bus.kill;
  assign accept = bus.op_vld && op_rdy;
  assign sgn_a  = bus.op_a[W-1] & ((bus.op == 2'b01) || (bus.op == 2'b10));

  // Partial products for this cycle's group of multiplier bits
  always_comb begin
    for (int j = 0; j < UNROLL; j++)
      pp[j] = b_q[j] ? (a_q << j) : '0;
  end

  // Sum the group into the accumulator; multiplier bit W-1 is subtracted for MULH
  always_comb begin
    sum = acc_q;
    for (int j = 0; j < UNROLL; j++) begin
      if (op_q == 2'b01 && last && j == UNROLL - 1) sum = sum - pp[j];
      else                                          sum = sum + pp[j];
    end
  end

  // Next state and datapath; kill overrides everything and blocks acceptance
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (bus.kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) state_d = BUSY;
        BUSY: begin
          acc_d = sum;
          a_d   = a_q << UNROLL;
          b_d   = b_q >> UNROLL;
          cnt_d = cnt_q + CW'(1);
          if (last) state_d = DONE;
        end
        DONE: if (bus.result_rdy) state_d = accept ? BUSY : IDLE;
        default: state_d = IDLE;
      endcase
      if (accept) begin
        op_d  = bus.op;
        a_d   = {{W{sgn_a}}, bus.op_a};
        b_d   = bus.op_b;
        acc_d = '0;
        cnt_d = '0;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.op_rdy     = op_rdy;
  assign bus.result_vld = (state_q == DONE);
  assign bus.result     = (op_q == 2'b00) ? acc_q[W-1:0] : acc_q[2*W-1:W];
endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: directed table, handshake corner sequences, random
// ops against an arithmetic reference, and extra W/UNROLL configurations.
module tb_mult_seq;
  logic clk, rst_n, rst_sub_n;
  int   checks = 0;
  int   failures = 0;

  mult_seq_if #(.W(32)) bus ();
  mult_seq #(.W(32), .UNROLL(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: signed/unsigned product of w-bit operands, then pick low or high half
  function automatic logic [31:0] ref_mul(input int w, input logic [1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, ax, bx, p;
    mask = (64'd1 << w) - 64'd1;
    ax = {32'd0, a} & mask;
    bx = {32'd0, b} & mask;
    if ((op == 2'b01 || op == 2'b10) && ax[w-1]) ax = ax | ~mask;
    if (op == 2'b01 && bx[w-1]) bx = bx | ~mask;
    p = ax * bx;
    return 32'(((op == 2'b00) ? p : (p >> w)) & mask);
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] mask;
    mask = 32'((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return mask;
      3: return 32'd1 << (w - 1);
      default: return $urandom & mask;
    endcase
  endfunction

  // Issue one op with result_rdy high; return result and cycles from accept to result_vld
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    bus.op = o; bus.op_a = a; bus.op_b = b; bus.op_vld = 1; bus.result_rdy = 1;
    @(negedge clk);
    bus.op_vld = 0;
    lat = 1;
    while (!bus.result_vld && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = bus.result;
  endtask

  task automatic watch_no_vld(input string nm, input int cycles);
    logic seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.result_vld) seen = 1;
    end
    chk(nm, 64'(seen), 64'd0);
  endtask

  // Extra configurations run concurrently on their own reset
  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int CW = (g == 3) ? 32 : 8;
    localparam int CU = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 32;
    bit done_f = 0;
    mult_seq_if #(.W(CW)) sif ();
    mult_seq #(.W(CW), .UNROLL(CU)) u_cfg (.clk(clk), .rst_n(rst_sub_n), .bus(sif));

    initial begin
      logic [31:0] a, b;
      logic [1:0]  o;
      int          lat;
      sif.op_vld = 0; sif.kill = 0; sif.result_rdy = 1;
      sif.op = 0; sif.op_a = '0; sif.op_b = '0;
      wait (rst_sub_n);
      for (int i = 0; i < 160; i++) begin
        @(negedge clk);
        o = 2'(i);
        a = pick(CW);
        b = pick(CW);
        sif.op = o; sif.op_a = CW'(a); sif.op_b = CW'(b); sif.op_vld = 1;
        @(negedge clk);
        sif.op_vld = 0;
        lat = 1;
        while (!sif.result_vld && lat < 80) begin
          @(negedge clk);
          lat++;
        end
        chk($sformatf("cfg W%0d U%0d latency", CW, CU), 64'(lat), 64'(CW / CU + 1));
        chk($sformatf("cfg W%0d U%0d op%0d %0h*%0h", CW, CU, o, a, b),
            64'(sif.result), 64'(ref_mul(CW, o, a, b)));
      end
      done_f = 1;
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, exp;
  } vec_t;

  initial begin
    vec_t        tbl[12];
    logic [31:0] res, a, b;
    logic [1:0]  o;
    int          lat;
    logic [3:0]  dn;

    tbl[0]  = '{2'b00, 32'h3,        32'h5,        32'h0000000F};
    tbl[1]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    tbl[2]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    tbl[3]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    tbl[4]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[5]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
    tbl[6]  = '{2'b11, 32'h7,        32'h9,        32'h00000000};
    tbl[7]  = '{2'b00, 32'h7,        32'h9,        32'h0000003F};
    tbl[8]  = '{2'b01, 32'h80000000, 32'h1,        32'hFFFFFFFF};
    tbl[9]  = '{2'b10, 32'h80000000, 32'h80000000, 32'hC0000000};
    tbl[10] = '{2'b11, 32'h80000000, 32'h80000000, 32'h40000000};
    tbl[11] = '{2'b00, 32'h12345678, 32'h10,       32'h23456780};

    bus.op_vld = 0; bus.kill = 0; bus.result_rdy = 1;
    bus.op = 0; bus.op_a = 0; bus.op_b = 0;
    rst_n = 0; rst_sub_n = 0;
    #1;
    chk("reset op_rdy", 64'(bus.op_rdy), 64'd1);
    chk("reset result_vld", 64'(bus.result_vld), 64'd0);
    chk("reset result", 64'(bus.result), 64'd0);
    #20;
    @(negedge clk);
    rst_n = 1; rst_sub_n = 1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'd9);
      chk($sformatf("vec%0d result", i), 64'(res), 64'(tbl[i].exp));
    end

    // Backpressure with a queued op released by result_rdy
    @(negedge clk);
    bus.op = 2'b00; bus.op_a = 32'd3; bus.op_b = 32'd5; bus.op_vld = 1; bus.result_rdy = 0;
    @(negedge clk);
    bus.op_vld = 0;
    lat = 1;
    while (!bus.result_vld && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp latency", 64'(lat), 64'd9);
    bus.op = 2'b00; bus.op_a = 32'd7; bus.op_b = 32'd9; bus.op_vld = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp result held", 64'(bus.result), 64'h0F);
      chk("bp vld held", 64'(bus.result_vld), 64'd1);
      chk("bp op_rdy low", 64'(bus.op_rdy), 64'd0);
      @(negedge clk);
    end
    bus.result_rdy = 1;
    #1;
    chk("bp op_rdy on result_rdy", 64'(bus.op_rdy), 64'd1);
    @(negedge clk);
    bus.op_vld = 0;
    lat = 1;
    while (!bus.result_vld && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp handoff latency", 64'(lat), 64'd9);
    chk("bp handoff result", 64'(bus.result), 64'h3F);

    // Kill during the third iteration
    @(negedge clk);
    bus.op = 2'b00; bus.op_a = 32'h1234; bus.op_b = 32'h5678; bus.op_vld = 1;
    @(negedge clk);
    bus.op_vld = 0;
    @(negedge clk);
    @(negedge clk);
    bus.kill = 1;
    #1;
    chk("kill op_rdy gated", 64'(bus.op_rdy), 64'd0);
    @(negedge clk);
    bus.kill = 0;
    #1;
    chk("post-kill op_rdy", 64'(bus.op_rdy), 64'd1);
    chk("post-kill result_vld", 64'(bus.result_vld), 64'd0);
    watch_no_vld("kill no result pulse", 12);
    run_op(2'b11, 32'd7, 32'd9, res, lat);
    chk("after kill MULHU", 64'(res), 64'd0);
    run_op(2'b00, 32'd7, 32'd9, res, lat);
    chk("after kill MUL", 64'(res), 64'h3F);
    chk("after kill latency", 64'(lat), 64'd9);

    // Kill in DONE alongside a consume and a would-be accept
    @(negedge clk);
    bus.op = 2'b00; bus.op_a = 32'd3; bus.op_b = 32'd5; bus.op_vld = 1; bus.result_rdy = 0;
    @(negedge clk);
    bus.op_vld = 0;
    lat = 1;
    while (!bus.result_vld && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("done-kill latency", 64'(lat), 64'd9);
    bus.op_a = 32'd7; bus.op_b = 32'd9; bus.op_vld = 1; bus.result_rdy = 1; bus.kill = 1;
    #1;
    chk("done-kill op_rdy", 64'(bus.op_rdy), 64'd0);
    @(negedge clk);
    bus.kill = 0; bus.op_vld = 0;
    #1;
    chk("done-kill result_vld", 64'(bus.result_vld), 64'd0);
    watch_no_vld("done-kill no accept", 12);

    // Asynchronous reset mid-BUSY
    @(negedge clk);
    bus.op = 2'b11; bus.op_a = 32'hFFFFFFFF; bus.op_b = 32'hFFFFFFFF; bus.op_vld = 1;
    @(negedge clk);
    bus.op_vld = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("midreset op_rdy", 64'(bus.op_rdy), 64'd1);
    chk("midreset result_vld", 64'(bus.result_vld), 64'd0);
    chk("midreset result", 64'(bus.result), 64'd0);
    @(negedge clk);
    rst_n = 1;
    run_op(2'b10, 32'h80000000, 32'h80000000, res, lat);
    chk("post-reset result", 64'(res), 64'hC0000000);
    chk("post-reset latency", 64'(lat), 64'd9);

    // Random ops against the reference
    for (int i = 0; i < 150; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick(32);
      b = pick(32);
      run_op(o, a, b, res, lat);
      chk($sformatf("rand op%0d %0h*%0h", o, a, b), 64'(res), 64'(ref_mul(32, o, a, b)));
      chk("rand latency", 64'(lat), 64'd9);
    end

    dn = '0;
    for (int i = 0; i < 30000 && dn != 4'hF; i++) begin
      @(negedge clk);
      dn = {g_cfg[3].done_f, g_cfg[2].done_f, g_cfg[1].done_f, g_cfg[0].done_f};
    end
    chk("config sweeps complete", 64'(dn), 64'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
